vid_frame_capture_ctrl: RTL and testbench

- Frame-gating controller between the RGB-to-AXI-Stream converter and the downstream frame writer.
- Arms on software start and locks onto the next start-of-frame (tuser).
- Passes a programmed number of whole frames, or runs continuously, and discards all other beats.
- Checks line and frame geometry; flags overflow, since the upstream source cannot be stalled.

---
 rtl/vid_frame_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vid_frame_capture_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_frame_capture_ctrl.sv
// Frame-gating controller: arms on start, locks to the next SOF, forwards whole
// frames (counted or continuous) and flags geometry errors and lost beats.
module vid_frame_capture_ctrl #(
  parameter int unsigned WIDTH  = 1600,
  parameter int unsigned HEIGHT = 900,
  parameter int unsigned DW     = 24
) (
  input  logic          vid_clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tuser,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tuser,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  input  logic [7:0]    frame_num,
  input  logic          err_clr,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frames_done,
  output logic          err_line,
  output logic          err_frame,
  output logic          err_ovf
);

  localparam int unsigned CW = 16;
  localparam int unsigned FW = 8;

  typedef enum logic [1:0] {IDLE, ARM, PASS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d;
  logic [CW-1:0] y_cnt_q, y_cnt_d;
  logic [FW-1:0] frames_q, frames_d;
  logic [FW-1:0] fnum_q, fnum_d;
  logic          cont_q, cont_d;
  logic          stop_pend_q, stop_pend_d;
  logic          done_q, done_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          err_ovf_q, err_ovf_d;

  logic          pass_c;
  logic          acc_c;
  logic          line_bad_c;
  logic          frame_end_c;
  logic [FW-1:0] frames_inc_c;

  // Zero-latency datapath; discarded beats are always consumed upstream.
  assign pass_c = (state_q == PASS) |
                  ((state_q == ARM) & s_axis_tvalid & s_axis_tuser);
  assign acc_c  = s_axis_tvalid & m_axis_tready & pass_c;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & pass_c;
  assign s_axis_tready = pass_c ? m_axis_tready : 1'b1;

  assign line_bad_c   = CW'(x_cnt_q + CW'(1)) != CW'(WIDTH);
  assign frame_end_c  = y_cnt_q == CW'(HEIGHT - 1);
  assign frames_inc_c = frames_q + FW'(1);

  always_comb begin
    state_d     = state_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    frames_d    = frames_q;
    fnum_d      = fnum_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    err_line_d  = err_clr ? 1'b0 : err_line_q;
    err_frame_d = err_clr ? 1'b0 : err_frame_q;
    err_ovf_d   = (err_clr ? 1'b0 : err_ovf_q) |
                  (pass_c & s_axis_tvalid & ~m_axis_tready);

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          frames_d = '0;
          fnum_d   = (frame_num == FW'(0)) ? FW'(1) : frame_num;
          cont_d   = continuous;
          state_d  = ARM;
        end
      end
      ARM: begin
        // A stop coinciding with the locking SOF lets that frame finish.
        if (acc_c) begin
          state_d     = PASS;
          x_cnt_d     = CW'(1);
          y_cnt_d     = '0;
          stop_pend_d = stop;
        end else if (stop) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end
      end
      PASS: begin
        if (stop) stop_pend_d = 1'b1;
        if (acc_c) begin
          if (s_axis_tuser) begin
            // Premature SOF: this beat becomes pixel 0 of a fresh frame.
            err_frame_d = 1'b1;
            x_cnt_d     = CW'(1);
            y_cnt_d     = '0;
          end else if (s_axis_tlast) begin
            if (line_bad_c) err_line_d = 1'b1;
            x_cnt_d = '0;
            if (frame_end_c) begin
              y_cnt_d  = '0;
              frames_d = frames_inc_c;
              if (stop_pend_q | stop | (~cont_q & (frames_inc_c == fnum_q))) begin
                state_d     = IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end else begin
                state_d = ARM;
              end
            end else begin
              y_cnt_d = y_cnt_q + CW'(1);
            end
          end else begin
            x_cnt_d = x_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vid_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      frames_q    <= '0;
      fnum_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      frames_q    <= frames_d;
      fnum_q      <= fnum_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign frames_done = frames_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_vid_frame_capture_ctrl.sv
// Bench for vid_frame_capture_ctrl with an 8x4 geometry: per-cycle vector table
// plus frame-level sequences checked through an expected-beat queue.
module tb_vid_frame_capture_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 24;

  logic          vid_clk, rst_n;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic          start, stop, continuous, err_clr;
  logic [7:0]    frame_num, frames_done;
  logic          busy, done, err_line, err_frame, err_ovf;

  vid_frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
    .vid_clk(vid_clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .start(start), .stop(stop), .continuous(continuous), .frame_num(frame_num),
    .err_clr(err_clr), .busy(busy), .done(done), .frames_done(frames_done),
    .err_line(err_line), .err_frame(err_frame), .err_ovf(err_ovf)
  );

  initial vid_clk = 1'b0;
  always #5 vid_clk = ~vid_clk;

  typedef struct {
    logic v, u, l, r, st, clr;
    logic e_mv, e_sr, e_busy, e_ovf;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  vec_t  tbl [12];
  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_errs   = 0;
  int    out_cnt  = 0;
  int    out_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop and compare one forwarded beat; call around the falling edge.
  task automatic sample();
    beat_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_beat", {6'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {6'd0, e});
      end
    end
  endtask

  task automatic finish_cycle();
    sample();
    @(posedge vid_clk);
    #1;
    start = 1'b0; stop = 1'b0; err_clr = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic idle_cyc();
    s_axis_tvalid = 1'b0;
    @(negedge vid_clk);
    finish_cycle();
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic u, input logic l, input bit exp);
    beat_t b;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tuser = u; s_axis_tlast = l;
    if (exp && m_axis_tready) begin
      b.d = d; b.u = u; b.l = l;
      sb_q.push_back(b);
    end
    @(negedge vid_clk);
    if (!exp) begin
      chk("discard_mvalid", 32'(m_axis_tvalid), 32'd0);
      chk("discard_sready", 32'(s_axis_tready), 32'd1);
    end
    finish_cycle();
  endtask

  task automatic send_line(input int len, input bit sof, input bit exp);
    for (int i = 0; i < len; i++)
      drive(DW'($urandom), sof && (i == 0), i == len - 1, exp);
  endtask

  task automatic send_frame(input bit exp);
    for (int y = 0; y < int'(H); y++) send_line(int'(W), y == 0, exp);
  endtask

  task automatic chk_end(input string name, input logic e_done, input logic [7:0] e_fd,
                         input logic e_busy);
    chk({name, "_done"}, 32'(done), 32'(e_done));
    chk({name, "_frames"}, 32'(frames_done), 32'(e_fd));
    chk({name, "_busy"}, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    // v u l r st clr | mvalid sready busy ovf
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1};

    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    start = 1'b0; stop = 1'b0; continuous = 1'b0; err_clr = 1'b0; frame_num = 8'd1;

    #2;
    chk_end("reset", 1'b0, 8'd0, 1'b0);
    chk("reset_flags", {29'd0, err_line, err_frame, err_ovf}, 32'd0);
    chk("reset_mvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge vid_clk);
    #1;
    rst_n = 1'b1;

    // Per-cycle vectors: IDLE discard, arm, SOF stall/accept, err_clr vs new stall.
    for (int i = 0; i < 12; i++) begin
      beat_t b;
      s_axis_tdata  = DW'(i * 17 + 3);
      s_axis_tvalid = tbl[i].v; s_axis_tuser = tbl[i].u; s_axis_tlast = tbl[i].l;
      m_axis_tready = tbl[i].r; start = tbl[i].st; err_clr = tbl[i].clr;
      if (tbl[i].e_mv && tbl[i].r) begin
        b.d = s_axis_tdata; b.u = tbl[i].u; b.l = tbl[i].l;
        sb_q.push_back(b);
      end
      @(negedge vid_clk);
      chk($sformatf("vec%0d_mvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].e_mv));
      chk($sformatf("vec%0d_sready", i), 32'(s_axis_tready), 32'(tbl[i].e_sr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_ovf", i), 32'(err_ovf), 32'(tbl[i].e_ovf));
      finish_cycle();
    end
    m_axis_tready = 1'b1;

    // Asynchronous reset while passing a frame.
    s_axis_tvalid = 1'b1;
    #2;
    chk("prerst_mvalid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_sready", 32'(s_axis_tready), 32'd1);
    chk_end("rst", 1'b0, 8'd0, 1'b0);
    chk("rst_flags", {29'd0, err_line, err_frame, err_ovf}, 32'd0);
    @(posedge vid_clk);
    #1;
    s_axis_tvalid = 1'b0;
    idle_cyc();
    rst_n = 1'b1;
    idle_cyc();

    // Single mode with frame_num=0 (acts as 1): one frame out, next discarded.
    frame_num = 8'd0; continuous = 1'b0;
    out_base = out_cnt;
    start = 1'b1;
    idle_cyc();
    chk("a_busy_armed", 32'(busy), 32'd1);
    send_frame(1'b1);
    chk_end("a_end", 1'b1, 8'd1, 1'b0);
    idle_cyc();
    chk("a_done_onecycle", 32'(done), 32'd0);
    send_frame(1'b0);
    chk("a_beats", 32'(out_cnt - out_base), 32'(W * H));

    // Start mid-frame: rest of that frame is skipped, next frame captured.
    frame_num = 8'd1;
    out_base  = out_cnt;
    send_line(int'(W), 1'b1, 1'b0);
    send_line(int'(W), 1'b0, 1'b0);
    start = 1'b1;
    send_line(int'(W), 1'b0, 1'b0);
    send_line(int'(W), 1'b0, 1'b0);
    chk("b_busy_armed", 32'(busy), 32'd1);
    send_frame(1'b1);
    chk_end("b_end", 1'b1, 8'd1, 1'b0);
    chk("b_beats", 32'(out_cnt - out_base), 32'(W * H));

    // Continuous mode, stop mid frame 2: frame 2 completes, frame 3 dropped.
    continuous = 1'b1;
    start = 1'b1;
    idle_cyc();
    send_frame(1'b1);
    chk_end("c_f1", 1'b0, 8'd1, 1'b1);
    send_line(int'(W), 1'b1, 1'b1);
    stop = 1'b1;
    send_line(int'(W), 1'b0, 1'b1);
    chk_end("c_stopreq", 1'b0, 8'd1, 1'b1);
    send_line(int'(W), 1'b0, 1'b1);
    send_line(int'(W), 1'b0, 1'b1);
    chk_end("c_end", 1'b1, 8'd2, 1'b0);
    send_frame(1'b0);
    chk("c_after_busy", 32'(busy), 32'd0);
    continuous = 1'b0;

    // Geometry: short line, then premature SOF, then err_clr.
    start = 1'b1;
    idle_cyc();
    send_line(int'(W), 1'b1, 1'b1);
    chk("d_line_ok", 32'(err_line), 32'd0);
    send_line(int'(W) - 1, 1'b0, 1'b1);
    chk("d_line_short", 32'(err_line), 32'd1);
    send_line(int'(W), 1'b0, 1'b1);
    send_line(int'(W), 1'b0, 1'b1);
    chk_end("d_f1", 1'b1, 8'd1, 1'b0);
    start = 1'b1;
    idle_cyc();
    chk("d_frames_cleared", 32'(frames_done), 32'd0);
    for (int y = 0; y < int'(H) - 1; y++) send_line(int'(W), y == 0, 1'b1);
    chk_end("d_3lines", 1'b0, 8'd0, 1'b1);
    chk("d_frame_ok", 32'(err_frame), 32'd0);
    send_frame(1'b1);
    chk_end("d_f2", 1'b1, 8'd1, 1'b0);
    chk("d_frame_err", 32'(err_frame), 32'd1);
    err_clr = 1'b1;
    idle_cyc();
    chk("d_clr", {30'd0, err_line, err_frame}, 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
